btn_cmd_arbiter: RTL

- Collects one-cycle press pulses from the per-button debounce/edge-detect instances and latches each as a pending event.
- Arbitrates pending events round-robin into a small command FIFO.
- Presents button codes one at a time to the game logic over a valid/ready handshake.
- Sits between the button debouncers and the game FSM, so simultaneous or closely spaced presses are neither lost nor merged into one.

---
 rtl/btn_pkg.sv | 15 +
 rtl/cmd_fifo.sv | 55 +++++
 rtl/btn_cmd_arbiter.sv | 102 ++++++++++
 3 files changed

// File: rtl/btn_pkg.sv
// Shared button-interface constants: default widths and the button code map.
package btn_pkg;

    localparam int unsigned N_BTN = 5;
    localparam int unsigned ID_W  = 3;

    typedef enum logic [ID_W-1:0] {
        BTN_UP    = 3'd0,
        BTN_DOWN  = 3'd1,
        BTN_LEFT  = 3'd2,
        BTN_RIGHT = 3'd3,
        BTN_FIRE  = 3'd4
    } btn_e;

endpackage

// File: rtl/cmd_fifo.sv
// Small synchronous command FIFO; overflowing pushes and empty pops are ignored.
module cmd_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 3,
    parameter int unsigned CNT_W = 3
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             push,
    input  logic [W-1:0]     din,
    input  logic             pop,
    output logic [W-1:0]     dout,
    output logic [CNT_W-1:0] count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic          do_push;
    logic          do_pop;

    always_comb begin
        do_push = push && (count != CNT_W'(DEPTH));
        do_pop  = pop && (count != '0);
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + CNT_W'(1);
            end else if (do_pop && !do_push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    assign dout = mem[rd_ptr];

endmodule

// File: rtl/btn_cmd_arbiter.sv
// Latches button press pulses as pending events and round-robin arbitrates
// them into a command FIFO presented over a valid/ready handshake.
module btn_cmd_arbiter #(
    parameter int unsigned N_BTN = btn_pkg::N_BTN,
    parameter int unsigned ID_W  = btn_pkg::ID_W,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 3
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [N_BTN-1:0] pulse,
    input  logic             cmd_ready,
    output logic             cmd_valid,
    output logic [ID_W-1:0]  cmd_code,
    output logic             lost,
    input  logic             lost_clr,
    output logic [N_BTN-1:0] pending
);

    import btn_pkg::*;

    logic [ID_W-1:0]  rr;
    logic [ID_W-1:0]  rr_next;
    logic [ID_W-1:0]  gidx;
    logic             grant;
    logic [N_BTN-1:0] pending_next;
    logic             lost_set;
    logic [CNT_W-1:0] count;

    // Search from rr upward with wrap; only the registered pending vector is seen.
    always_comb begin
        int unsigned idx;
        logic        found;
        found = 1'b0;
        gidx  = '0;
        for (int unsigned k = 0; k < N_BTN; k++) begin
            idx = int'(rr) + k;
            if (idx >= N_BTN) begin
                idx = idx - N_BTN;
            end
            if (!found && pending[idx]) begin
                found = 1'b1;
                gidx  = ID_W'(idx);
            end
        end
        grant   = found && (count != CNT_W'(DEPTH));
        rr_next = rr;
        if (grant) begin
            rr_next = (gidx == ID_W'(N_BTN - 1)) ? '0 : gidx + ID_W'(1);
        end
    end

    always_comb begin
        logic granted_i;
        pending_next = pending;
        lost_set     = 1'b0;
        for (int unsigned i = 0; i < N_BTN; i++) begin
            granted_i = grant && (gidx == ID_W'(i));
            if (pulse[i]) begin
                pending_next[i] = 1'b1;
                if (pending[i] && !granted_i) begin
                    lost_set = 1'b1;
                end
            end else if (granted_i) begin
                pending_next[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            pending <= '0;
            rr      <= '0;
            lost    <= 1'b0;
        end else begin
            pending <= pending_next;
            rr      <= rr_next;
            if (lost_set) begin
                lost <= 1'b1;
            end else if (lost_clr) begin
                lost <= 1'b0;
            end
        end
    end

    cmd_fifo #(
        .DEPTH (DEPTH),
        .W     (ID_W),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk   (clk),
        .clr   (clr),
        .push  (grant),
        .din   (gidx),
        .pop   (cmd_ready),
        .dout  (cmd_code),
        .count (count)
    );

    assign cmd_valid = (count != '0);

endmodule
